// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: operand-fetch / writeback arbiter in front of a 2R/1W-exclusive register file.
// Latency: request accept edge T -> op_valid high after edge T+2; writebacks buffered in a 2-entry FIFO.
// Backpressure: req_ready only in IDLE with an empty FIFO and no writeback offered; wb_ready while FIFO not full.
//
// Ports:
//   clk, reset (async, active-low), en (0 freezes all state, gates all strobes/readies)
//   req_valid/req_ready, req_rs1/req_rs2      : operand-fetch request
//   op_valid/op_ready, op_a/op_b              : operand result
//   wb_valid/wb_ready, wb_rd/wb_data          : writeback
//   rs1/rs2/readEn, readOut1/readOut2         : register-file read port
//   rd/dataIn/writeEn                         : register-file write port
//
// Build option: define RF_ZERO_REG_EN to treat x0 as hard-wired zero (writebacks to x0 are
// acknowledged but dropped; reads of x0 return 0). Undefined: x0 is an ordinary register.
module rf_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        readEn,
  output logic [4:0]  rd,
  output logic [31:0] dataIn,
  output logic        writeEn,
  input  logic [31:0] readOut1,
  input  logic [31:0] readOut2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Writeback FIFO: two entries, ping-pong pointers.
  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic [4:0]  lat_rs1;
  logic [4:0]  lat_rs2;
  logic [4:0]  rs1_hold;
  logic [4:0]  rs2_hold;
  logic [4:0]  rd_hold;
  logic [31:0] data_hold;

  logic        wb_fire;
  logic        push;
  logic        pop;
  logic        req_fire;
  logic [31:0] op_a_nxt;
  logic [31:0] op_b_nxt;

  // Handshake and strobe generation. Reads only happen in READ and writes only in
  // IDLE/OUT, so readEn and writeEn can never be high in the same cycle.
  assign wb_ready  = en && (count != 2'd2);
  assign wb_fire   = wb_valid && wb_ready;
  // A pending writeback blocks new requests so the write is ordered before the read.
  assign req_ready = en && (state == IDLE) && (count == 2'd0) && !wb_valid;
  assign req_fire  = req_valid && req_ready;
  assign readEn    = en && (state == READ);
  assign pop       = en && ((state == IDLE) || (state == OUT)) && (count != 2'd0);
  assign writeEn   = pop;

`ifdef RF_ZERO_REG_EN
  // x0 writebacks complete their handshake but never reach the register file.
  assign push     = wb_fire && (wb_rd != 5'd0);
  assign op_a_nxt = (lat_rs1 == 5'd0) ? 32'd0 : readOut1;
  assign op_b_nxt = (lat_rs2 == 5'd0) ? 32'd0 : readOut2;
`else
  assign push     = wb_fire;
  assign op_a_nxt = readOut1;
  assign op_b_nxt = readOut2;
`endif

  // Address/data ports show the live value while strobed and the last strobed value otherwise.
  assign rs1    = readEn  ? lat_rs1            : rs1_hold;
  assign rs2    = readEn  ? lat_rs2            : rs2_hold;
  assign rd     = writeEn ? fifo_rd[rd_ptr]    : rd_hold;
  assign dataIn = writeEn ? fifo_data[rd_ptr]  : data_hold;

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (req_fire) state_nxt = READ;
        READ:    state_nxt = CAPT;
        CAPT:    state_nxt = OUT;
        OUT:     if (op_valid && op_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      op_valid  <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      lat_rs1   <= 5'd0;
      lat_rs2   <= 5'd0;
      rs1_hold  <= 5'd0;
      rs2_hold  <= 5'd0;
      rd_hold   <= 5'd0;
      data_hold <= 32'd0;
    end else if (en) begin
      state <= state_nxt;

      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        rd_hold   <= fifo_rd[rd_ptr];
        data_hold <= fifo_data[rd_ptr];
      end

      if (req_fire) begin
        lat_rs1 <= req_rs1;
        lat_rs2 <= req_rs2;
      end
      if (readEn) begin
        rs1_hold <= lat_rs1;
        rs2_hold <= lat_rs2;
      end

      // Register-file data is valid in the cycle after the READ edge.
      if (state == CAPT) begin
        op_a     <= op_a_nxt;
        op_b     <= op_b_nxt;
        op_valid <= 1'b1;
      end else if ((state == OUT) && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= wb_rd;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl: table of operand fetches plus hand-written multi-cycle sequences.
// Register file is modelled behaviourally; initial content of register i is 0xA0000000 | i.
// Summary line reports errors and total checks.
module tb_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        readEn;
  logic [4:0]  rd;
  logic [31:0] dataIn;
  logic        writeEn;
  logic [31:0] readOut1 = 32'd0;
  logic [31:0] readOut2 = 32'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_access_ctrl dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .readEn(readEn),
    .rd(rd), .dataIn(dataIn), .writeEn(writeEn),
    .readOut1(readOut1), .readOut2(readOut2)
  );

  // Behavioural register file following the read/write contract.
  logic [31:0] regs [32];
  logic        rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA000_0000 | i;
      rf_loaded <= 1'b1;
    end else begin
      if (writeEn && !readEn) regs[rd] <= dataIn;
      if (readEn && !writeEn) begin
        readOut1 <= regs[rs1];
        readOut2 <= regs[rs2];
      end
    end
  end

  // Strobe monitor.
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          both_cnt = 0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_dat = 32'd0;
  always @(negedge clk) begin
    if (reset) begin
      if (writeEn) begin
        we_cnt++;
        last_rd = rd;
        last_dat = dataIn;
      end
      if (readEn) re_cnt++;
      if (readEn && writeEn) both_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // Called shortly after a negedge; returns at a negedge after the push edge.
  task automatic send_wb(input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wb_valid = 1'b1; wb_rd = a; wb_data = d;
    while (!wb_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wb_ready) timeout_fail("send_wb");
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Returns at a negedge with op_valid high (OUT); waited = negedges spent before req_ready,
  // lat = edges from accept until op_valid observed.
  task automatic do_req(input logic [4:0] a1, input logic [4:0] a2, output int waited, output int lat);
    req_valid = 1'b1; req_rs1 = a1; req_rs2 = a2;
    waited = 0; lat = 0;
    #1;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      timeout_fail("do_req accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (!op_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!op_valid) timeout_fail("do_req op_valid");
  endtask

  typedef struct {
    logic        do_wb;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] ea;
    logic [31:0] eb;
    int          ewe;
  } vec_t;

`ifdef RF_ZERO_REG_EN
  localparam logic [31:0] X0_INIT = 32'd0;
  localparam logic [31:0] X0_WB   = 32'd0;
  localparam int          X0_WE   = 0;
`else
  localparam logic [31:0] X0_INIT = 32'hA000_0000;
  localparam logic [31:0] X0_WB   = 32'h0000_0055;
  localparam int          X0_WE   = 1;
`endif

  vec_t vecs [6];

  initial begin
    int waited;
    int lat;
    int we0;
    int re0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd0,  32'hDEAD_BEEF, X0_INIT,       1};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'hA000_0001, 32'hA000_0002, 0};
    vecs[2] = '{1'b1, 5'd31, 32'h1234_5678, 5'd30, 5'd31, 32'hA000_001E, 32'h1234_5678, 1};
    vecs[3] = '{1'b1, 5'd7,  32'hCAFE_F00D, 5'd7,  5'd7,  32'hCAFE_F00D, 32'hCAFE_F00D, 1};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 0};
    vecs[5] = '{1'b1, 5'd0,  32'h55,        5'd0,  5'd5,  X0_WB,         32'hDEAD_BEEF, X0_WE};

    reset = 1'b0; en = 1'b1; req_valid = 1'b0; req_rs1 = 5'd0; req_rs2 = 5'd0;
    op_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #1;
    chk("reset op_valid", op_valid, 0);
    chk("reset op_a", op_a, 0);
    chk("reset op_b", op_b, 0);
    chk("reset readEn", readEn, 0);
    chk("reset writeEn", writeEn, 0);
    chk("reset rs1", rs1, 0);
    chk("reset rs2", rs2, 0);
    chk("reset rd", rd, 0);
    chk("reset dataIn", dataIn, 0);
    chk("reset wb_ready", wb_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Table: optional writeback then operand fetch.
    for (int i = 0; i < 6; i++) begin
      #1;
      we0 = we_cnt; re0 = re_cnt;
      if (vecs[i].do_wb) send_wb(vecs[i].wrd, vecs[i].wdat);
      do_req(vecs[i].a1, vecs[i].a2, waited, lat);
      chk($sformatf("vec%0d op_a", i), op_a, vecs[i].ea);
      chk($sformatf("vec%0d op_b", i), op_b, vecs[i].eb);
      chk($sformatf("vec%0d latency", i), lat, 2);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d writeEn pulses", i), we_cnt - we0, vecs[i].ewe);
      chk($sformatf("vec%0d readEn pulses", i), re_cnt - re0, 1);
      chk($sformatf("vec%0d op_valid cleared", i), op_valid, 0);
      if (vecs[i].ewe != 0) begin
        chk($sformatf("vec%0d write rd", i), last_rd, vecs[i].wrd);
        chk($sformatf("vec%0d write data", i), last_dat, vecs[i].wdat);
      end
    end

    // Writeback and request offered together: write is ordered first.
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd1;
    #1;
    chk("same-cycle req_ready", req_ready, 0);
    chk("same-cycle wb_ready", wb_ready, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("same-cycle drain writeEn", writeEn, 1);
    chk("same-cycle drain rd", rd, 5'd3);
    chk("same-cycle drain dataIn", dataIn, 32'h11);
    chk("same-cycle req blocked", req_ready, 0);
    do_req(5'd3, 5'd1, waited, lat);
    chk("same-cycle accept wait", waited, 1);
    chk("same-cycle op_a", op_a, 32'h11);
    chk("same-cycle op_b", op_b, 32'hA000_0001);
    @(negedge clk);
    #1;

    // en=0 freezes the FSM in READ and in OUT.
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd5;
    #1;
    chk("freeze req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    en = 1'b0;
    #1;
    chk("freeze readEn forced", readEn, 0);
    chk("freeze wb_ready forced", wb_ready, 0);
    chk("freeze req_ready forced", req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("freeze hold op_valid %0d", k), op_valid, 0);
    end
    en = 1'b1;
    #1;
    chk("freeze resume readEn", readEn, 1);
    chk("freeze resume rs1", rs1, 5'd3);
    lat = 0;
    while (!op_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("freeze resume latency", lat, 2);
    chk("freeze op_a", op_a, 32'h11);
    chk("freeze op_b", op_b, 32'hDEAD_BEEF);
    en = 1'b0;
    @(negedge clk);
    #1;
    chk("freeze OUT op_valid held", op_valid, 1);
    en = 1'b1;
    @(negedge clk);
    #1;
    chk("freeze OUT consumed", op_valid, 0);

    // Three writebacks during a stalled fetch; FIFO fills, then drains in order during OUT.
    op_ready = 1'b0;
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd7;
    #1;
    chk("stall req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h1010;
    #1;
    chk("stall READ readEn", readEn, 1);
    chk("stall wb_ready count0", wb_ready, 1);
    @(negedge clk);
    wb_rd = 5'd11; wb_data = 32'h2020;
    #1;
    chk("stall wb_ready count1", wb_ready, 1);
    chk("stall CAPT writeEn", writeEn, 0);
    @(negedge clk);
    wb_rd = 5'd12; wb_data = 32'h3030;
    #1;
    chk("stall wb_ready full", wb_ready, 0);
    chk("stall op_valid", op_valid, 1);
    chk("stall drain1 writeEn", writeEn, 1);
    chk("stall drain1 rd", rd, 5'd10);
    chk("stall drain1 dataIn", dataIn, 32'h1010);
    @(negedge clk);
    #1;
    chk("stall wb_ready after pop", wb_ready, 1);
    chk("stall drain2 rd", rd, 5'd11);
    chk("stall drain2 dataIn", dataIn, 32'h2020);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("stall drain3 writeEn", writeEn, 1);
    chk("stall drain3 rd", rd, 5'd12);
    chk("stall drain3 dataIn", dataIn, 32'h3030);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall hold%0d op_valid", k), op_valid, 1);
      chk($sformatf("stall hold%0d op_a", k), op_a, 32'hDEAD_BEEF);
      chk($sformatf("stall hold%0d op_b", k), op_b, 32'hCAFE_F00D);
      chk($sformatf("stall hold%0d req_ready", k), req_ready, 0);
      chk($sformatf("stall hold%0d writeEn", k), writeEn, 0);
    end
    op_ready = 1'b1;
    do_req(5'd10, 5'd12, waited, lat);
    chk("release accept wait", waited, 1);
    chk("release op_a", op_a, 32'h1010);
    chk("release op_b", op_b, 32'h3030);
    chk("release latency", lat, 2);
    @(negedge clk);
    #1;

    // Reset mid-fetch with one buffered writeback.
    req_valid = 1'b1; req_rs1 = 5'd20; req_rs2 = 5'd1;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h77;
    #1;
    chk("rst-mid READ readEn", readEn, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("rst-mid CAPT writeEn", writeEn, 0);
    reset = 1'b0;
    #1;
    chk("rst-mid op_valid", op_valid, 0);
    chk("rst-mid op_a", op_a, 0);
    chk("rst-mid readEn", readEn, 0);
    chk("rst-mid writeEn", writeEn, 0);
    chk("rst-mid rs1", rs1, 0);
    chk("rst-mid rd", rd, 0);
    chk("rst-mid req_ready (idle, empty)", req_ready, 1);
    we0 = we_cnt; re0 = re_cnt;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst-mid no writeEn after", we_cnt - we0, 0);
    chk("rst-mid no readEn after", re_cnt - re0, 0);
    chk("rst-mid op_valid after", op_valid, 0);
    do_req(5'd20, 5'd1, waited, lat);
    chk("rst-mid accept wait", waited, 0);
    chk("rst-mid x20 untouched", op_a, 32'hA000_0014);
    chk("rst-mid x1 untouched", op_b, 32'hA000_0001);
    @(negedge clk);
    #1;

    chk("readEn/writeEn overlap cycles", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; reset in 1, async active-low (0 = reset asserted).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- en  in  1  block enable; 0 freezes all state.
- req_valid  in  1; req_ready  out  1  operand-fetch request handshake.
- req_rs1  in  5; req_rs2  in  5  source register addresses.
- op_valid  out  1; op_ready  in  1  operand result handshake.
- op_a  out  32; op_b  out  32  operands for rs1 and rs2.
- wb_valid  in  1; wb_ready  out  1  writeback handshake.
- wb_rd  in  5; wb_data  in  32  writeback address and data.
- rs1  out  5; rs2  out  5; readEn  out  1  register-file read port.
- rd  out  5; dataIn  out  32; writeEn  out  1  register-file write port.
- readOut1  in  32; readOut2  in  32  register-file read data.
REQ-003 SHALL assume the register-file contract: a read samples at the posedge when readEn=1 and writeEn=0, and its data is valid after that edge; a write commits at the posedge when writeEn=1 and readEn=0.

Function
REQ-004 SHALL implement FSM states IDLE, READ, CAPT and OUT.
REQ-005 SHALL contain a 2-entry writeback FIFO {rd, data} with count 0..2; wb_ready = en && count<2; push on wb_valid && wb_ready.
REQ-006 SHALL make req_ready = en && state==IDLE && count==0 && !wb_valid.
- A writeback presented in the same cycle as a request is ordered first.
REQ-007 On request accept, SHALL latch req_rs1/req_rs2 and move IDLE->READ.
REQ-008 In READ, SHALL drive readEn=1, writeEn=0 and rs1/rs2 = latched addresses, then go to CAPT.
REQ-009 In CAPT, SHALL load op_a=readOut1 and op_b=readOut2, set op_valid=1 and go to OUT.
- Latency: accept edge T, op_valid high after edge T+2.
REQ-010 In OUT, SHALL hold op_a/op_b/op_valid stable until op_valid && op_ready, then clear op_valid and return to IDLE.
REQ-011 SHALL drain the FIFO head when state is IDLE or OUT, en=1 and count>0.
- Drive writeEn=1, readEn=0, rd/dataIn = head; pop at the edge.
REQ-012 SHALL never assert readEn and writeEn together; writeEn=0 in READ and CAPT.
REQ-013 Simultaneous push and pop SHALL update count by net zero and preserve FIFO order.
- Push into a full FIFO is impossible because wb_ready=0.
REQ-014 When en=0, SHALL hold all registers and force readEn=writeEn=req_ready=wb_ready=0.
- op_valid and op data stay unchanged.
REQ-015 When readEn=0, rs1/rs2 SHALL hold their last values; when writeEn=0, rd/dataIn SHALL hold their last values.

Reset
REQ-016 reset=0 SHALL immediately, and independently of clk, set:
- state=IDLE, count=0, FIFO pointers=0;
- op_valid=0, op_a=op_b=0;
- latched addresses=0, rs1=rs2=rd=0, dataIn=0.
REQ-017 Reset mid-transaction SHALL discard any in-flight read and all buffered writebacks; no readEn or writeEn pulse occurs afterwards until a new handshake.

Configuration
REQ-018 Macro RF_ZERO_REG_EN SHALL select x0 handling.
- Defined: a writeback with rd=0 completes its handshake but is not pushed and issues no writeEn. op_a is forced to 0 when the latched rs1==0; op_b is forced to 0 when the latched rs2==0.
- Undefined: x0 is an ordinary register.

Verification
REQ-019 Reset, then wb (rd=5, data=0xDEADBEEF) followed by req (rs1=5, rs2=0) -> one writeEn pulse with rd=5, then a readEn pulse; op_a=0xDEADBEEF, op_valid exactly 2 cycles after accept.
REQ-020 wb_valid and req_valid in the same cycle (rd=3, data=0x11; rs1=3) -> req_ready=0 that cycle; the write drains first; op_a=0x11.
REQ-021 Three back-to-back wb with op_ready=0 -> wb_ready drops after the 2nd push; entries drain in order during OUT; readEn and writeEn are never both high.
REQ-022 op_ready held 0 for 10 cycles -> op_a/op_b/op_valid stable; req_ready=0; accept occurs the cycle after release.
REQ-023 reset pulsed in READ with one FIFO entry pending -> op_valid=0, count=0, no subsequent writeEn.
REQ-024 With RF_ZERO_REG_EN: wb (rd=0, data=0x55) then req (rs1=0) -> no writeEn, op_a=0; without the macro -> writeEn issued, op_a=0x55.
